// File: rtl/uc_rx.sv
// ============================================================================
// Module   : uc_rx
// Purpose  : UART receiver. Oversamples RX at OVERSAMPLE x baud, recovers
//            5..8 data bits (LSB first), optional odd/even parity and 1 or 2
//            stop bits, and pushes each frame into the RX FIFO together with
//            per-frame parity/frame error flags.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            RX                  - serial input, idle high, asynchronous
//            baudrate_clk_en     - one-clk pulse at OVERSAMPLE x baud
//            transaction_en      - high from validated start to frame end
//            data_out_rx         - received data, right-justified
//            fifo_wr             - one-clk FIFO write strobe
//            fifo_full           - FIFO full, frame is dropped when set
//            parity_error        - parity mismatch, valid with fifo_wr
//            frame_error         - a stop-bit sample was 0, valid with fifo_wr
//            overrun_error       - one-clk pulse when a frame is dropped
//            data_width_option   - 00=5, 01=6, 10=7, 11=8 data bits
//            parity_option       - 10=odd, 11=even, 0x=none
//            stop_bit_option     - 0=1 stop bit, 1=2 stop bits
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uc_rx #(
  parameter int DATA_WIDTH          = 8,
  parameter int OVERSAMPLE          = 16,
  parameter int SAMPLE_POINT        = 7,
  parameter int DATA_WIDTH_OPTION_W = 2,
  parameter int PARITY_OPTION_W     = 2,
  parameter int STOP_BIT_OPTION_W   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           RX,
  input  logic                           baudrate_clk_en,
  output logic                           transaction_en,
  output logic [DATA_WIDTH-1:0]          data_out_rx,
  output logic                           fifo_wr,
  input  logic                           fifo_full,
  output logic                           parity_error,
  output logic                           frame_error,
  output logic                           overrun_error,
  input  logic [DATA_WIDTH_OPTION_W-1:0] data_width_option,
  input  logic [PARITY_OPTION_W-1:0]     parity_option,
  input  logic [STOP_BIT_OPTION_W-1:0]   stop_bit_option
);

  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_WIDTH);
  localparam int SHW = BW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;
  localparam logic [2:0] S_WAIT   = 3'd6;

  logic                           rx_meta_q, rx_s_q;
  logic [2:0]                     state_q, state_d;
  logic [TW-1:0]                  tick_q, tick_d;
  logic [BW-1:0]                  bit_q, bit_d;
  logic [DATA_WIDTH-1:0]          shift_q, shift_d;
  logic [DATA_WIDTH_OPTION_W-1:0] width_q, width_d;
  logic [PARITY_OPTION_W-1:0]     par_q, par_d;
  logic [STOP_BIT_OPTION_W-1:0]   stop_q, stop_d;
  logic                           perr_q, perr_d;
  logic                           ferr_q, ferr_d;
  logic                           txn_q, txn_d;
  logic [DATA_WIDTH-1:0]          dout_q, dout_d;
  logic                           wr_q, wr_d;
  logic                           pe_q, pe_d;
  logic                           fe_q, fe_d;
  logic                           ovr_q, ovr_d;

  logic                           w_sample;
  logic [TW-1:0]                  w_tick_nxt;
  logic [SHW-1:0]                 w_shamt;
  logic                           w_exp_par;
  logic                           w_done;
  logic                           w_fe_final;

  assign w_sample   = baudrate_clk_en && (tick_q == TW'(SAMPLE_POINT));
  assign w_tick_nxt = (tick_q == TW'(OVERSAMPLE - 1)) ? '0 : tick_q + 1'b1;
  // Bits are shifted in at the MSB, so a short frame ends up left-justified
  // and must be moved down by (DATA_WIDTH - number of bits received).
  assign w_shamt    = SHW'(DATA_WIDTH - 5) - SHW'(width_q);
  // Unreceived shift-register bits stay 0, so a full-width XOR only sees
  // the received data. Even: bit = ^data; odd: bit = ~^data.
  assign w_exp_par  = (^shift_q) ^ ~par_q[0];

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    width_d    = width_q;
    par_d      = par_q;
    stop_d     = stop_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    txn_d      = txn_q;
    dout_d     = dout_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    wr_d       = 1'b0;
    ovr_d      = 1'b0;
    w_done     = 1'b0;
    w_fe_final = 1'b0;

    if (baudrate_clk_en) begin
      tick_d = w_tick_nxt;
      case (state_q)
        S_IDLE: begin
          tick_d = '0;
          if (!rx_s_q) state_d = S_START;
        end
        S_START: begin
          if (w_sample) begin
            if (!rx_s_q) begin
              width_d = data_width_option;
              par_d   = parity_option;
              stop_d  = stop_bit_option;
              bit_d   = BW'(data_width_option) + BW'(4);
              shift_d = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
              txn_d   = 1'b1;
              state_d = S_DATA;
            end else begin
              tick_d  = '0;
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_sample) begin
            shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
            if (bit_q == '0) begin
              state_d = par_q[1] ? S_PARITY : S_STOP1;
            end else begin
              bit_d = bit_q - 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_sample) begin
            perr_d  = rx_s_q ^ w_exp_par;
            state_d = S_STOP1;
          end
        end
        S_STOP1: begin
          if (w_sample) begin
            ferr_d = ~rx_s_q;
            if (stop_q[0]) begin
              state_d = S_STOP2;
            end else begin
              w_done     = 1'b1;
              w_fe_final = ~rx_s_q;
            end
          end
        end
        S_STOP2: begin
          if (w_sample) begin
            w_done     = 1'b1;
            w_fe_final = ferr_q | ~rx_s_q;
          end
        end
        S_WAIT: begin
          tick_d = '0;
          if (rx_s_q) state_d = S_IDLE;
        end
        default: begin
          tick_d  = '0;
          state_d = S_IDLE;
        end
      endcase
    end

    if (w_done) begin
      txn_d  = 1'b0;
      tick_d = '0;
      if (!fifo_full) begin
        wr_d   = 1'b1;
        dout_d = shift_q >> w_shamt;
        pe_d   = perr_q;
        fe_d   = w_fe_final;
      end else begin
        ovr_d  = 1'b1;
      end
      // A line still low here is a break; wait for it to release before
      // looking for the next start bit.
      state_d = rx_s_q ? S_IDLE : S_WAIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      width_q   <= '0;
      par_q     <= '0;
      stop_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      txn_q     <= 1'b0;
      dout_q    <= '0;
      wr_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      width_q   <= width_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      txn_q     <= txn_d;
      dout_q    <= dout_d;
      wr_q      <= wr_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign transaction_en = txn_q;
  assign data_out_rx    = dout_q;
  assign fifo_wr        = wr_q;
  assign parity_error   = pe_q;
  assign frame_error    = fe_q;
  assign overrun_error  = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uc_rx.sv
// ============================================================================
// Module   : tb_uc_rx
// Purpose  : Directed self-checking bench for uc_rx. Baud tick every 4 clk,
//            so one bit period is 64 clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uc_rx;

  localparam int BP = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       baud = 1'b0;
  logic       fifo_full;
  logic [1:0] dwo;
  logic [1:0] po;
  logic       so;
  logic       txn;
  logic [7:0] dout;
  logic       wr;
  logic       pe;
  logic       fe;
  logic       ovr;

  int div_cnt = 0;
  int wr_cnt = 0;
  int ovr_cycles = 0;
  int txn_cycles = 0;
  int n_tests = 0;
  int n_fail = 0;
  int w0, o0, t0;

  uc_rx dut (
    .clk               (clk),
    .rst               (rst),
    .RX                (RX),
    .baudrate_clk_en   (baud),
    .transaction_en    (txn),
    .data_out_rx       (dout),
    .fifo_wr           (wr),
    .fifo_full         (fifo_full),
    .parity_error      (pe),
    .frame_error       (fe),
    .overrun_error     (ovr),
    .data_width_option (dwo),
    .parity_option     (po),
    .stop_bit_option   (so)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (div_cnt == 3) begin
      div_cnt <= 0;
      baud    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      baud    <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (wr)  wr_cnt     <= wr_cnt + 1;
    if (ovr) ovr_cycles <= ovr_cycles + 1;
    if (txn) txn_cycles <= txn_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    RX = v;
    repeat (BP) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                            input logic par_bit, input int nstop, input logic stop2_val,
                            input bit chk_txn);
    bit_time(1'b0);
    for (int i = 0; i < nbits; i++) bit_time(data[i]);
    if (has_par) bit_time(par_bit);
    bit_time(1'b1);
    if (nstop == 2) begin
      RX = stop2_val;
      repeat (16) @(negedge clk);
      if (chk_txn) check("txn_during_stop2", {31'b0, txn}, 32'd1);
      repeat (BP - 16) @(negedge clk);
    end
    RX = 1'b1;
    repeat (2 * BP) @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; RX = 1'b1; fifo_full = 1'b0;
    dwo = 2'b11; po = 2'b00; so = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txn",  {31'b0, txn}, 32'd0);
    check("rst_data", {24'b0, dout}, 32'd0);
    check("rst_wr",   {31'b0, wr},  32'd0);
    check("rst_pe",   {31'b0, pe},  32'd0);
    check("rst_fe",   {31'b0, fe},  32'd0);
    check("rst_ovr",  {31'b0, ovr}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 8N1 0xA5
    w0 = wr_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    check("8n1_wr",   wr_cnt - w0, 1);
    check("8n1_data", {24'b0, dout}, 32'hA5);
    check("8n1_pe",   {31'b0, pe}, 32'd0);
    check("8n1_fe",   {31'b0, fe}, 32'd0);
    check("8n1_txn",  {31'b0, txn}, 32'd0);

    // 7E1 0x35: four ones -> even parity bit 0
    dwo = 2'b10; po = 2'b11; so = 1'b0;
    w0 = wr_cnt;
    send_frame(8'h35, 7, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    check("7e1_wr",   wr_cnt - w0, 1);
    check("7e1_data", {24'b0, dout}, 32'h35);
    check("7e1_pe",   {31'b0, pe}, 32'd0);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    check("7e1_bad_data", {24'b0, dout}, 32'h35);
    check("7e1_bad_pe",   {31'b0, pe}, 32'd1);

    // 5O2 0x1F: five ones -> odd parity bit 0; second stop bit driven low
    dwo = 2'b00; po = 2'b10; so = 1'b1;
    w0 = wr_cnt;
    send_frame(8'h1F, 5, 1'b1, 1'b0, 2, 1'b0, 1'b1);
    check("5o2_wr",   wr_cnt - w0, 1);
    check("5o2_data", {24'b0, dout}, 32'h1F);
    check("5o2_fe",   {31'b0, fe}, 32'd1);
    check("5o2_pe",   {31'b0, pe}, 32'd0);
    check("5o2_txn",  {31'b0, txn}, 32'd0);

    // Start-bit glitch of 4 ticks
    dwo = 2'b11; po = 2'b00; so = 1'b0;
    w0 = wr_cnt; t0 = txn_cycles;
    RX = 1'b0;
    repeat (16) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BP) @(negedge clk);
    check("glitch_wr",  wr_cnt - w0, 0);
    check("glitch_txn", txn_cycles - t0, 0);

    // Overrun: FIFO full during 0x3C, outputs keep the previous frame
    fifo_full = 1'b1;
    w0 = wr_cnt; o0 = ovr_cycles;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    fifo_full = 1'b0;
    check("ovr_wr",     wr_cnt - w0, 0);
    check("ovr_pulse",  ovr_cycles - o0, 1);
    check("ovr_data",   {24'b0, dout}, 32'h1F);
    check("ovr_fe",     {31'b0, fe}, 32'd1);
    w0 = wr_cnt;
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    check("after_ovr_wr",   wr_cnt - w0, 1);
    check("after_ovr_data", {24'b0, dout}, 32'hC3);
    check("after_ovr_fe",   {31'b0, fe}, 32'd0);

    // Reset in the middle of DATA (frame 0x81 partially sent)
    w0 = wr_cnt;
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    bit_time(1'b0);
    RX = 1'b0;
    repeat (BP / 2) @(negedge clk);
    check("mid_txn_before", {31'b0, txn}, 32'd1);
    #1 rst = 1'b1;
    RX = 1'b1;
    #1;
    check("mid_rst_txn",  {31'b0, txn}, 32'd0);
    check("mid_rst_data", {24'b0, dout}, 32'd0);
    check("mid_rst_wr",   {31'b0, wr},  32'd0);
    check("mid_rst_fe",   {31'b0, fe},  32'd0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BP) @(negedge clk);
    check("mid_rst_nowr", wr_cnt - w0, 0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    check("post_rst_wr",   wr_cnt - w0, 1);
    check("post_rst_data", {24'b0, dout}, 32'h81);
    check("post_rst_pe",   {31'b0, pe}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
